// File: rtl/voice_allocator.sv
// voice_allocator: maps held PS/2 note keys onto four voice channels.
// Idle channels drive 8'hF0, which the frequency stage treats as sound-off.
module voice_allocator #(
   parameter bit STEAL_EN = 1'b1
) (
   input  logic       VGA_CLK,
   input  logic       RESET_N,
   input  logic [7:0] scan_code,
   input  logic       scan_ready,
   input  logic       panic,
   output logic [7:0] scan_code1,
   output logic [7:0] scan_code2,
   output logic [7:0] scan_code3,
   output logic [7:0] scan_code4,
   output logic [2:0] voice_count,
   output logic [1:0] steal_ptr
);

   localparam logic [7:0] OFF   = 8'hF0;
   localparam logic [7:0] EXT_B = 8'hE0;

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

   state_t           state_q, state_d;
   logic [3:0][7:0]  ch_q, ch_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             is_note, do_make, do_brk;
   logic             hit, free_vld;
   logic [1:0]       free_idx;

   always_comb begin
      is_note = 1'b0;
      case (scan_code)
         8'h15, 8'h1C, 8'h1D, 8'h1B, 8'h24,
         8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
         8'h33, 8'h3B, 8'h43, 8'h42, 8'h44,
         8'h4B, 8'h4D, 8'h4C, 8'h52, 8'h5B: is_note = 1'b1;
         default:                           is_note = 1'b0;
      endcase
   end

   // Descending scan so the lowest free channel wins.
   always_comb begin
      hit      = 1'b0;
      free_vld = 1'b0;
      free_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (ch_q[i] == scan_code) hit = 1'b1;
         if (ch_q[i] == OFF) begin
            free_vld = 1'b1;
            free_idx = 2'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      do_make = 1'b0;
      do_brk  = 1'b0;
      if (scan_ready) begin
         unique case (state_q)
            IDLE: begin
               if (scan_code == OFF)        state_d = BRK;
               else if (scan_code == EXT_B) state_d = EXT;
               else                         do_make = is_note;
            end
            BRK: begin
               if (scan_code == OFF)        state_d = BRK;
               else if (scan_code == EXT_B) state_d = EXT;
               else begin
                  state_d = IDLE;
                  do_brk  = is_note;
               end
            end
            EXT: begin
               if (scan_code == OFF)        state_d = EXT_BRK;
               else if (scan_code == EXT_B) state_d = EXT;
               else                         state_d = IDLE;
            end
            EXT_BRK: state_d = IDLE;
         endcase
      end
      if (panic) begin
         state_d = IDLE;
         do_make = 1'b0;
         do_brk  = 1'b0;
      end
   end

   always_comb begin
      ch_d  = ch_q;
      ptr_d = ptr_q;
      if (panic) begin
         ch_d  = {4{OFF}};
         ptr_d = 2'd0;
      end else if (do_make && !hit) begin
         if (free_vld) begin
            ch_d[free_idx] = scan_code;
         end else if (STEAL_EN) begin
            ch_d[ptr_q] = scan_code;
            ptr_d       = ptr_q + 2'd1;
         end
      end else if (do_brk) begin
         for (int i = 0; i < 4; i++)
            if (ch_q[i] == scan_code) ch_d[i] = OFF;
      end
      cnt_d = 3'd0;
      for (int i = 0; i < 4; i++)
         if (ch_d[i] != OFF) cnt_d = cnt_d + 3'd1;
   end

   always_ff @(posedge VGA_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         ch_q    <= {4{OFF}};
         ptr_q   <= 2'd0;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign scan_code1  = ch_q[0];
   assign scan_code2  = ch_q[1];
   assign scan_code3  = ch_q[2];
   assign scan_code4  = ch_q[3];
   assign voice_count = cnt_q;
   assign steal_ptr   = ptr_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: steal and drop variants run side by side
// against a prefix-flag / channel-list reference model.
module tb_voice_allocator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] sc;
   logic       sr;
   logic       pn;
   logic [7:0] a1, a2, a3, a4, b1, b2, b3, b4;
   logic [2:0] ac, bc;
   logic [1:0] ap, bp;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   voice_allocator #(.STEAL_EN(1'b1)) u_st (
      .VGA_CLK(clk), .RESET_N(rst_n), .scan_code(sc),
      .scan_ready(sr), .panic(pn),
      .scan_code1(a1), .scan_code2(a2), .scan_code3(a3),
      .scan_code4(a4), .voice_count(ac), .steal_ptr(ap)
   );

   voice_allocator #(.STEAL_EN(1'b0)) u_dr (
      .VGA_CLK(clk), .RESET_N(rst_n), .scan_code(sc),
      .scan_ready(sr), .panic(pn),
      .scan_code1(b1), .scan_code2(b2), .scan_code3(b3),
      .scan_code4(b4), .voice_count(bc), .steal_ptr(bp)
   );

   // Model: index 0 = drop variant, index 1 = steal variant.
   logic [7:0] m_ch [2][4];
   int         m_ptr [2];
   bit         m_ext, m_brk;
   logic [7:0] NOTES [20] = '{8'h15, 8'h1C, 8'h1D, 8'h1B, 8'h24,
                              8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
                              8'h33, 8'h3B, 8'h43, 8'h42, 8'h44,
                              8'h4B, 8'h4D, 8'h4C, 8'h52, 8'h5B};

   function automatic bit note(logic [7:0] b);
      foreach (NOTES[i]) if (NOTES[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_clear();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) m_ch[d][i] = 8'hF0;
         m_ptr[d] = 0;
      end
      m_ext = 0;
      m_brk = 0;
   endtask

   task automatic m_make(logic [7:0] k);
      for (int d = 0; d < 2; d++) begin
         bit done;
         done = 0;
         for (int i = 0; i < 4; i++) if (m_ch[d][i] == k) done = 1;
         for (int i = 0; i < 4 && !done; i++)
            if (m_ch[d][i] == 8'hF0) begin
               m_ch[d][i] = k;
               done = 1;
            end
         if (!done && d == 1) begin
            m_ch[d][m_ptr[d]] = k;
            m_ptr[d] = (m_ptr[d] + 1) % 4;
         end
      end
   endtask

   task automatic m_byte(logic [7:0] b);
      if (m_ext && m_brk) begin
         m_ext = 0; m_brk = 0;
      end else if (m_ext) begin
         if (b == 8'hF0) m_brk = 1;
         else if (b != 8'hE0) m_ext = 0;
      end else if (m_brk) begin
         if (b == 8'hE0) begin
            m_ext = 1; m_brk = 0;
         end else if (b != 8'hF0) begin
            m_brk = 0;
            if (note(b))
               for (int d = 0; d < 2; d++)
                  for (int i = 0; i < 4; i++)
                     if (m_ch[d][i] == b) m_ch[d][i] = 8'hF0;
         end
      end else begin
         if (b == 8'hF0) m_brk = 1;
         else if (b == 8'hE0) m_ext = 1;
         else if (note(b)) m_make(b);
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(string tag);
      for (int d = 0; d < 2; d++) begin
         logic [31:0] obs, exp;
         int n;
         n = 0;
         exp = {m_ch[d][0], m_ch[d][1], m_ch[d][2], m_ch[d][3]};
         for (int i = 0; i < 4; i++) if (m_ch[d][i] != 8'hF0) n++;
         obs = (d == 1) ? {a1, a2, a3, a4} : {b1, b2, b3, b4};
         chk($sformatf("%s/ch%0d", tag, d), obs, exp);
         chk($sformatf("%s/cnt%0d", tag, d),
             32'(d == 1 ? ac : bc), 32'(n));
         chk($sformatf("%s/ptr%0d", tag, d),
             32'(d == 1 ? ap : bp), 32'(m_ptr[d]));
      end
   endtask

   task automatic chk_inv(string tag);
      logic [7:0] v [8];
      int bad;
      v = '{a1, a2, a3, a4, b1, b2, b3, b4};
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (v[i] != 8'hF0 && !note(v[i])) bad++;
         for (int j = i + 1; j < 8; j++)
            if ((i < 4) == (j < 4) && v[i] == v[j] && v[i] != 8'hF0)
               bad++;
      end
      chk(tag, 32'(bad), 32'd0);
   endtask

   task automatic send(logic [7:0] b);
      @(negedge clk);
      sc = b;
      sr = 1'b1;
      @(negedge clk);
      sr = 1'b0;
      sc = 8'h00;
      m_byte(b);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      m_clear();
      #1 chk_model("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_panic(logic [7:0] b, logic with_byte);
      @(negedge clk);
      pn = 1'b1;
      sr = with_byte;
      sc = b;
      @(negedge clk);
      pn = 1'b0;
      sr = 1'b0;
      m_clear();
   endtask

   initial begin
      rst_n = 1'b1;
      sc = 8'h00;
      sr = 1'b0;
      pn = 1'b0;
      m_clear();
      do_reset();

      send(8'h1C); send(8'h1B); send(8'h23);
      chk("three_notes", {a1, a2, a3, a4}, 32'h1C1B23F0);
      chk("three_cnt", 32'(ac), 32'd3);
      chk_model("three");
      send(8'hF0); send(8'h1B);
      chk_model("break_1B");
      send(8'h2B);
      chk("reuse_ch2", 32'(a2), 32'h2B);
      chk_model("reuse");

      do_reset();
      send(8'h34); send(8'h34); send(8'h34);
      chk_model("typematic");
      send(8'hF0); send(8'h34);
      chk_model("typematic_rel");

      do_reset();
      send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
      send(8'h34);
      chk("steal_ch1", 32'(a1), 32'h34);
      chk("steal_ptr", 32'(ap), 32'd1);
      chk("drop_keep", {b1, b2, b3, b4}, 32'h1C1B232B);
      chk_model("steal1");
      send(8'h33);
      chk("steal_ch2", 32'(a2), 32'h33);
      chk_model("steal2");

      do_reset();
      send(8'h1C);
      send(8'hE0); send(8'h75);
      chk_model("ext_75");
      send(8'hE0); send(8'hF0); send(8'h1C);
      chk("ext_brk_hold", 32'(a1), 32'h1C);
      chk_model("ext_brk");
      send(8'hF0); send(8'hF0); send(8'h1C);
      chk_model("dbl_f0");
      send(8'h1D);
      send(8'h29);
      chk_model("space");

      @(negedge clk);
      sc = 8'h42;
      sr = 1'b0;
      @(negedge clk);
      chk_model("no_strobe");

      send(8'h15); send(8'h24);
      do_panic(8'h42, 1'b1);
      chk({a1, a2, a3, a4} == 32'hF0F0F0F0 ? "panic_ok" : "panic_ch",
          {a1, a2, a3, a4}, 32'hF0F0F0F0);
      chk_model("panic");

      send(8'hF0);
      do_reset();
      send(8'h1C);
      chk("rst_brk_make", 32'(a1), 32'h1C);
      chk_model("rst_brk");

      for (int n = 0; n < 600; n++) begin
         int r;
         logic [7:0] b;
         r = $urandom_range(0, 99);
         if (r < 55)      b = NOTES[$urandom_range(0, 19)];
         else if (r < 72) b = 8'hF0;
         else if (r < 80) b = 8'hE0;
         else if (r < 86) b = (r[0]) ? 8'h29 : 8'h75;
         else if (r < 95) b = 8'($urandom);
         else             b = 8'h00;
         if (r >= 98) do_panic(NOTES[$urandom_range(0, 19)], r[0]);
         else if (r >= 95) begin
            @(negedge clk);
            sc = 8'($urandom);
         end else send(b);
         chk_model($sformatf("rand%0d", n));
         chk_inv($sformatf("inv%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Sits directly upstream of the four-channel note-to-frequency stage.
- Consumes the decoded PS/2 keyboard byte stream (make codes, F0 break prefix, E0 extended prefix).
- Assigns each held note key to one of four voice channels and drives per-channel 8-bit scan codes.
- An idle channel drives 8'hF0, which the downstream stage treats as sound-off.

Parameters:
- STEAL_EN, 1, 1 = a new note with all channels busy steals a channel round-robin; 0 = the new note is dropped.

Ports:
- VGA_CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- scan_code  in  8  received PS/2 byte, valid only when scan_ready=1.
- scan_ready  in  1  single-cycle strobe, one per received byte.
- panic  in  1  synchronous all-notes-off.
- scan_code1  out  8  channel-1 key code, 8'hF0 when idle.
- scan_code2  out  8  channel-2 key code, 8'hF0 when idle.
- scan_code3  out  8  channel-3 key code, 8'hF0 when idle.
- scan_code4  out  8  channel-4 key code, 8'hF0 when idle.
- voice_count  out  3  number of non-idle channels, 0..4.
- steal_ptr  out  2  next channel to steal, for debug.

Behaviour:
- Reset (RESET_N=0, asynchronous): scan_code1..4=8'hF0, voice_count=0, steal_ptr=0, FSM=IDLE. Reset mid-sequence discards any pending prefix.
- Note set (20 codes): 15,1C,1D,1B,24,23,2B,2C,34,35,33,3B,43,42,44,4B,4D,4C,52,5B (hex). Any other non-prefix byte is ignored in every state.
- FSM states: IDLE, BRK, EXT, EXT_BRK. Transitions happen only on scan_ready=1.
  - IDLE: byte F0 -> BRK. Byte E0 -> EXT. Note code -> MAKE action, stay IDLE. Other byte -> stay IDLE.
  - BRK: byte F0 -> stay BRK. Byte E0 -> EXT. Any other byte -> BREAK action if it is a note code, then -> IDLE.
  - EXT: byte F0 -> EXT_BRK. Byte E0 -> stay EXT. Any other byte -> IDLE, no action.
  - EXT_BRK: any byte -> IDLE, no action.
- MAKE action on code K:
  - If any channel already holds K (typematic repeat): no change.
  - Else the lowest-index channel holding F0 loads K.
  - Else, if STEAL_EN=1: the channel at steal_ptr loads K and steal_ptr increments, wrapping 3->0.
  - Else, if STEAL_EN=0: drop K.
- BREAK action on code K: every channel holding K loads F0. If no channel holds K, no change. steal_ptr is unchanged.
- Latency: outputs and voice_count update on the clock edge that samples scan_ready=1, so they are visible in the following cycle. voice_count is registered and consistent with the channel outputs in the same cycle.
- panic=1: all channels -> F0, voice_count=0, FSM -> IDLE, steal_ptr -> 0. panic takes priority over a simultaneous scan_ready byte, which is discarded.
- Invariants:
  - No two channels ever hold the same non-F0 code.
  - Channel outputs only ever take a note-set code or F0.
- scan_code is ignored whenever scan_ready=0.

Test Plan:
- Reset then bytes 1C, 1B, 23 -> scan_code1=1C, scan_code2=1B, scan_code3=23, scan_code4=F0, voice_count=3.
- From that state, bytes F0,1B -> scan_code2=F0, voice_count=2. Next byte 2B -> scan_code2=2B (lowest free channel reused), voice_count=3.
- Typematic: bytes 34,34,34 from reset -> only scan_code1=34, voice_count=1. Then F0,34 -> all channels F0.
- Steal with STEAL_EN=1:
  - Load 1C,1B,23,2B, then 34 -> scan_code1=34, steal_ptr=1.
  - Then 33 -> scan_code2=33, steal_ptr=2.
  - With STEAL_EN=0, the same 34 leaves 1C,1B,23,2B unchanged.
- Prefix and filter handling:
  - Bytes E0,75 -> no change.
  - E0,F0,1C while 1C is held -> 1C remains held.
  - F0,F0,1C -> 1C released.
  - Byte 29 (space, non-note) -> no change.
- panic asserted together with scan_ready carrying 42 while 3 voices are active -> all outputs F0, voice_count=0, 42 not loaded. RESET_N pulsed low in BRK state, then byte 1C -> treated as a make, scan_code1=1C.
